// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO: depth helper and read-mode constants.
package sync_fifo_pkg;

  // Read-port mode selectors for the FALLTHROUGH parameter.
  localparam string FT_TRUE  = "TRUE";
  localparam string FT_FALSE = "FALSE";

  // Number of storage words for a given address width.
  function automatic int unsigned depth(input int unsigned addrsize);
    return 32'd1 << addrsize;
  endfunction

endpackage

// File: rtl/sfifo_ram.sv
// FIFO storage array: one write port, read port either fall-through or registered.
module sfifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATASIZE    = 8,
  parameter int unsigned ADDRSIZE    = 4,
  parameter string       FALLTHROUGH = FT_TRUE
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [ADDRSIZE-1:0] waddr_i,
  input  logic [DATASIZE-1:0] wdata_i,
  input  logic                re_i,
  input  logic [ADDRSIZE-1:0] raddr_i,
  output logic [DATASIZE-1:0] rdata_o
);

  localparam int unsigned Depth  = depth(ADDRSIZE);
  localparam bit          FtMode = (FALLTHROUGH == FT_TRUE);

  logic [DATASIZE-1:0] mem_q [Depth];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  if (FtMode) begin : g_fallthrough
    // Head word is presented directly; no read strobe or reset needed.
    logic unused_ft;
    assign unused_ft = ^{rst_ni, re_i};
    assign rdata_o   = mem_q[raddr_i];
  end else begin : g_registered
    logic [DATASIZE-1:0] rdata_q, rdata_d;

    // Capture the head word only on an accepted read; otherwise hold.
    always_comb begin
      rdata_d = rdata_q;
      if (re_i) begin
        rdata_d = mem_q[raddr_i];
      end
    end

    // Registered read data, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign rdata_o = rdata_q;
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, status flags, occupancy count and error pulses around sfifo_ram.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATASIZE    = 8,
  parameter int unsigned ADDRSIZE    = 4,
  parameter string       FALLTHROUGH = FT_TRUE,
  parameter int unsigned AFULL_LVL   = depth(ADDRSIZE) - 2,
  parameter int unsigned AEMPTY_LVL  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rd_en,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam bit                FtMode    = (FALLTHROUGH == FT_TRUE);
  localparam logic [ADDRSIZE:0] AfullLvl  = AFULL_LVL[ADDRSIZE:0];
  localparam logic [ADDRSIZE:0] AemptyLvl = AEMPTY_LVL[ADDRSIZE:0];

  // Pointers carry one extra wrap bit above the array address.
  logic [ADDRSIZE:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              wr_acc, rd_acc;

  // Status decoded from registered pointers only, so no path from wr_en/rd_en.
  assign empty        = (wptr_q == rptr_q);
  assign full         = (wptr_q[ADDRSIZE] != rptr_q[ADDRSIZE]) &&
                        (wptr_q[ADDRSIZE-1:0] == rptr_q[ADDRSIZE-1:0]);
  assign count        = wptr_q - rptr_q;
  assign almost_full  = (count >= AfullLvl);
  assign almost_empty = (count <= AemptyLvl);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Pointer advance and rejected-request detection.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = wr_en && full;
    underflow_d = rd_en && empty;
    if (wr_acc) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (rd_acc) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  // Pointer and error-pulse state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sfifo_ram #(
    .DATASIZE   (DATASIZE),
    .ADDRSIZE   (ADDRSIZE),
    .FALLTHROUGH(FALLTHROUGH)
  ) u_ram (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .we_i   (wr_acc),
    .waddr_i(wptr_q[ADDRSIZE-1:0]),
    .wdata_i(wdata),
    .re_i   (rd_acc),
    .raddr_i(rptr_q[ADDRSIZE-1:0]),
    .rdata_o(rdata)
  );

  if (FtMode) begin : g_rvalid_ft
    assign rvalid = !empty;
  end else begin : g_rvalid_reg
    logic rvalid_q, rvalid_d;

    // Registered data is valid only in the cycle following an accepted read.
    always_comb begin
      rvalid_d = rd_acc;
    end

    // Read-valid flag for the registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rvalid_d;
      end
    end

    assign rvalid = rvalid_q;
  end

endmodule
